// File: rtl/wt_dcache_inv_ctrl.sv
// Invalidation sequencer for the write-through L1 dcache arrays.
// Drives the full-cacheline write port either to walk every set (flush)
// or to clear individual lines queued in a small in-order FIFO.
//
// Handshake: wr_cl_vld_o is held with stable idx/we until wr_cl_gnt_i is
// seen in the same cycle; it is never retracted once raised in FLUSH.
// inv_req_i/inv_ack_o: a request is taken on any cycle where both are high.
module wt_dcache_inv_ctrl #(
    parameter int unsigned NumSets      = 256,
    parameter int unsigned SetAssoc     = 8,
    parameter int unsigned IdxWidth     = $clog2(NumSets),
    parameter int unsigned InvFifoDepth = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    output logic                flush_ack_o,
    output logic                busy_o,
    input  logic                inv_req_i,
    output logic                inv_ack_o,
    input  logic [IdxWidth-1:0] inv_idx_i,
    input  logic [SetAssoc-1:0] inv_way_i,
    input  logic                miss_busy_i,
    input  logic                wbuffer_empty_i,
    input  logic                wr_cl_gnt_i,
    output logic                wr_cl_vld_o,
    output logic [SetAssoc-1:0] wr_cl_we_o,
    output logic [IdxWidth-1:0] wr_cl_idx_o,
    output logic [SetAssoc-1:0] wr_vld_bits_o
);

    localparam int unsigned PtrWidth = $clog2(InvFifoDepth);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumSets - 1);
    localparam logic [PtrWidth:0] FullCount = (PtrWidth + 1)'(InvFifoDepth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic [IdxWidth-1:0] cnt_q, cnt_d;

    logic [IdxWidth-1:0] fifo_idx_q [InvFifoDepth];
    logic [SetAssoc-1:0] fifo_way_q [InvFifoDepth];
    logic [PtrWidth-1:0] rd_ptr_q, wr_ptr_q;
    logic [PtrWidth:0]   count_q;

    logic fifo_empty, fifo_full;
    logic push, pop, fifo_clear;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCount);

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign inv_ack_o = inv_req_i & (state_q == IDLE) & ~flush_i & (~fifo_full | pop);
    assign push      = inv_ack_o;

    assign busy_o        = (state_q != IDLE) | ~fifo_empty;
    assign wr_vld_bits_o = '0;

    // Next-state and write-port outputs; idx/we stay zero whenever vld is low.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_cl_vld_o = 1'b0;
        wr_cl_we_o  = '0;
        wr_cl_idx_o = '0;
        flush_ack_o = 1'b0;
        pop         = 1'b0;
        fifo_clear  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    // A flush wipes every line, so queued single invalidates are moot.
                    state_d    = DRAIN;
                    fifo_clear = 1'b1;
                end else if (!fifo_empty) begin
                    wr_cl_vld_o = 1'b1;
                    wr_cl_idx_o = fifo_idx_q[rd_ptr_q];
                    wr_cl_we_o  = fifo_way_q[rd_ptr_q];
                    pop         = wr_cl_gnt_i;
                end
            end
            DRAIN: begin
                if (wbuffer_empty_i && !miss_busy_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                wr_cl_vld_o = 1'b1;
                wr_cl_we_o  = '1;
                wr_cl_idx_o = cnt_q;
                if (wr_cl_gnt_i) begin
                    cnt_d = cnt_q + IdxWidth'(1);
                    if (cnt_q == LastIdx) state_d = DONE;
                end
            end
            DONE: begin
                flush_ack_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, set counter and FIFO pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (fifo_clear) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
                count_q <= count_q + (PtrWidth + 1)'(push) - (PtrWidth + 1)'(pop);
            end
        end
    end

    // FIFO payload storage; contents are only meaningful below count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q] <= inv_idx_i;
            fifo_way_q[wr_ptr_q] <= inv_way_i;
        end
    end

endmodule

// File: tb/tb_wt_dcache_inv_ctrl.sv
// Directed bench for wt_dcache_inv_ctrl with 4 sets and 4 ways.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_wt_dcache_inv_ctrl;

    localparam int NumSets  = 4;
    localparam int SetAssoc = 4;
    localparam int IdxWidth = 2;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    logic                flush_i, flush_ack_o, busy_o;
    logic                inv_req_i, inv_ack_o;
    logic [IdxWidth-1:0] inv_idx_i;
    logic [SetAssoc-1:0] inv_way_i;
    logic                miss_busy_i, wbuffer_empty_i, wr_cl_gnt_i;
    logic                wr_cl_vld_o;
    logic [SetAssoc-1:0] wr_cl_we_o;
    logic [IdxWidth-1:0] wr_cl_idx_o;
    logic [SetAssoc-1:0] wr_vld_bits_o;

    int vectors = 0;
    int errors  = 0;

    wt_dcache_inv_ctrl #(
        .NumSets     (NumSets),
        .SetAssoc    (SetAssoc),
        .IdxWidth    (IdxWidth),
        .InvFifoDepth(2)
    ) u_dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .flush_ack_o    (flush_ack_o),
        .busy_o         (busy_o),
        .inv_req_i      (inv_req_i),
        .inv_ack_o      (inv_ack_o),
        .inv_idx_i      (inv_idx_i),
        .inv_way_i      (inv_way_i),
        .miss_busy_i    (miss_busy_i),
        .wbuffer_empty_i(wbuffer_empty_i),
        .wr_cl_gnt_i    (wr_cl_gnt_i),
        .wr_cl_vld_o    (wr_cl_vld_o),
        .wr_cl_we_o     (wr_cl_we_o),
        .wr_cl_idx_o    (wr_cl_idx_o),
        .wr_vld_bits_o  (wr_vld_bits_o)
    );

    // Compare the full output bundle {vld, we, idx, fack, iack, busy, vld_bits}.
    task automatic expect_out(input string tag, input logic vld, input logic [3:0] we,
                              input logic [1:0] idx, input logic fack,
                              input logic iack, input logic busy);
        logic [13:0] obs, exp;
        obs = {wr_cl_vld_o, wr_cl_we_o, wr_cl_idx_o, flush_ack_o, inv_ack_o, busy_o, wr_vld_bits_o};
        exp = {vld, we, idx, fack, iack, busy, 4'h0};
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s {vld,we,idx,fack,iack,busy,vbits} observed=%b_%h_%0d_%b_%b_%b_%h expected=%b_%h_%0d_%b_%b_%b_%h",
                   tag, obs[13], obs[12:9], obs[8:7], obs[6], obs[5], obs[4], obs[3:0],
                   exp[13], exp[12:9], exp[8:7], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; inv_req_i = 1'b0; inv_idx_i = '0; inv_way_i = '0;
        miss_busy_i = 1'b0; wbuffer_empty_i = 1'b1; wr_cl_gnt_i = 1'b0;
        step(); step();
        #1 expect_out("reset_hold", 0, 4'h0, 0, 0, 0, 0);
        step(); rst_i = 1'b0;
        #1 expect_out("post_reset_idle", 0, 4'h0, 0, 0, 0, 0);

        // ---- basic flush, grant always high ----
        step(); flush_i = 1'b1; wr_cl_gnt_i = 1'b1;
        #1 expect_out("flush_req_idle", 0, 4'h0, 0, 0, 0, 0);
        step();
        #1 expect_out("flush_drain", 0, 4'h0, 0, 0, 0, 1);
        for (int i = 0; i < NumSets; i++) begin
            step();
            #1 expect_out($sformatf("flush_idx%0d", i), 1, 4'hF, i[1:0], 0, 0, 1);
        end
        step();
        #1 expect_out("flush_done_ack", 0, 4'h0, 0, 1, 0, 1);
        flush_i = 1'b0;
        step();
        #1 expect_out("flush_back_idle", 0, 4'h0, 0, 0, 0, 0);

        // ---- drain stall, then grant backpressure at idx 2 ----
        step(); flush_i = 1'b1; miss_busy_i = 1'b1;
        #1 expect_out("stall_req_idle", 0, 4'h0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            #1 expect_out($sformatf("stall_drain%0d", i), 0, 4'h0, 0, 0, 0, 1);
        end
        step(); miss_busy_i = 1'b0;
        #1 expect_out("stall_release", 0, 4'h0, 0, 0, 0, 1);
        step();
        #1 expect_out("stall_first_idx0", 1, 4'hF, 0, 0, 0, 1);
        step();
        #1 expect_out("bp_idx1", 1, 4'hF, 1, 0, 0, 1);
        step(); wr_cl_gnt_i = 1'b0;
        #1 expect_out("bp_idx2_nognt0", 1, 4'hF, 2, 0, 0, 1);
        step();
        #1 expect_out("bp_idx2_nognt1", 1, 4'hF, 2, 0, 0, 1);
        step();
        #1 expect_out("bp_idx2_nognt2", 1, 4'hF, 2, 0, 0, 1);
        step(); wr_cl_gnt_i = 1'b1;
        #1 expect_out("bp_idx2_gnt", 1, 4'hF, 2, 0, 0, 1);
        step();
        #1 expect_out("bp_idx3", 1, 4'hF, 3, 0, 0, 1);
        step();
        #1 expect_out("bp_done_ack", 0, 4'h0, 0, 1, 0, 1);
        flush_i = 1'b0;
        step();
        #1 expect_out("bp_back_idle", 0, 4'h0, 0, 0, 0, 0);

        // ---- FIFO order and full (set indices fit a 4-set cache) ----
        step(); wr_cl_gnt_i = 1'b0; inv_req_i = 1'b1; inv_idx_i = 2'd1; inv_way_i = 4'b0001;
        #1 expect_out("fifo_enq_a_empty", 0, 4'h0, 0, 0, 1, 0);
        step(); inv_idx_i = 2'd2; inv_way_i = 4'b0100;
        #1 expect_out("fifo_enq_b", 1, 4'b0001, 1, 0, 1, 1);
        step(); inv_idx_i = 2'd3; inv_way_i = 4'b1000;
        #1 expect_out("fifo_full_reject", 1, 4'b0001, 1, 0, 0, 1);
        step(); wr_cl_gnt_i = 1'b1;
        #1 expect_out("fifo_full_pop_accept", 1, 4'b0001, 1, 0, 1, 1);
        step(); inv_req_i = 1'b0;
        #1 expect_out("fifo_issue_b", 1, 4'b0100, 2, 0, 0, 1);
        step();
        #1 expect_out("fifo_issue_c", 1, 4'b1000, 3, 0, 0, 1);
        step();
        #1 expect_out("fifo_empty_idle", 0, 4'h0, 0, 0, 0, 0);

        // ---- flush wipes a populated FIFO ----
        step(); wr_cl_gnt_i = 1'b0; inv_req_i = 1'b1; inv_idx_i = 2'd1; inv_way_i = 4'b0001;
        #1 expect_out("fvf_enq_a", 0, 4'h0, 0, 0, 1, 0);
        step(); inv_idx_i = 2'd2; inv_way_i = 4'b0010;
        #1 expect_out("fvf_enq_b", 1, 4'b0001, 1, 0, 1, 1);
        step(); flush_i = 1'b1; inv_idx_i = 2'd3; inv_way_i = 4'b1000;
        #1 expect_out("fvf_flush_priority", 0, 4'h0, 0, 0, 0, 1);
        step(); wr_cl_gnt_i = 1'b1;
        #1 expect_out("fvf_drain", 0, 4'h0, 0, 0, 0, 1);
        for (int i = 0; i < NumSets; i++) begin
            step();
            #1 expect_out($sformatf("fvf_idx%0d", i), 1, 4'hF, i[1:0], 0, 0, 1);
        end
        step();
        #1 expect_out("fvf_done_ack", 0, 4'h0, 0, 1, 0, 1);
        flush_i = 1'b0; inv_req_i = 1'b0;
        step();
        #1 expect_out("fvf_fifo_cleared", 0, 4'h0, 0, 0, 0, 0);
        step();
        #1 expect_out("fvf_still_idle", 0, 4'h0, 0, 0, 0, 0);

        // ---- reset in the middle of a flush ----
        step(); flush_i = 1'b1; wr_cl_gnt_i = 1'b1;
        #1 expect_out("rst_req_idle", 0, 4'h0, 0, 0, 0, 0);
        step();
        #1 expect_out("rst_drain", 0, 4'h0, 0, 0, 0, 1);
        step();
        #1 expect_out("rst_idx0", 1, 4'hF, 0, 0, 0, 1);
        step();
        #1 expect_out("rst_idx1", 1, 4'hF, 1, 0, 0, 1);
        step(); rst_i = 1'b1;
        #1 expect_out("rst_idx2_pre", 1, 4'hF, 2, 0, 0, 1);
        step(); rst_i = 1'b0; flush_i = 1'b0;
        #1 expect_out("rst_after", 0, 4'h0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            #1 expect_out($sformatf("rst_no_ack%0d", i), 0, 4'h0, 0, 0, 0, 0);
        end
        step(); flush_i = 1'b1;
        #1 expect_out("rst_reflush_idle", 0, 4'h0, 0, 0, 0, 0);
        step();
        #1 expect_out("rst_reflush_drain", 0, 4'h0, 0, 0, 0, 1);
        for (int i = 0; i < NumSets; i++) begin
            step();
            #1 expect_out($sformatf("rst_reflush_idx%0d", i), 1, 4'hF, i[1:0], 0, 0, 1);
        end
        step();
        #1 expect_out("rst_reflush_ack", 0, 4'h0, 0, 1, 0, 1);
        flush_i = 1'b0;
        step();
        #1 expect_out("rst_reflush_idle_end", 0, 4'h0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
